nn_test_sequencer: RTL and testbench
====================================

Name: nn_test_sequencer

Overview:
Drives a campaign of inferences through the NeuralNetwork core and scores the results.
- Selects a test-vector address and pulses the core's start.
- Waits for its finish and compares result against the label read from the label Memory.
- Accumulates correct/total counts, then raises done.
- Sits beside NeuralNetwork: upstream, because it produces start and test_addr; downstream, because it consumes finish and result. Replaces ad-hoc scoring in benches and allows on-chip accuracy measurement.

Parameters:
ADDR_W, 10, width of test_addr.
NUM_VECTORS, 750, number of stored test vectors; address space wraps modulo this value.
NUM_TESTS, 100, inferences per campaign (1..65535).
STRIDE, 1, address increment per test, applied modulo NUM_VECTORS (0 < STRIDE < NUM_VECTORS).
SETUP_CYC, 2, idle cycles after an address change before start is issued (covers the 1-cycle label Memory read latency).
TIMEOUT, 4096, maximum cycles to wait for finish before the test is scored as wrong.

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-low reset (logic reset when rst==0 at a clk edge)
go  input  1  single-cycle pulse; starts a campaign; ignored unless in IDLE or DONE
base_addr  input  ADDR_W  first test address; sampled on go; must be < NUM_VECTORS
nn_finish  input  1  finish level from NeuralNetwork
nn_result  input  4  predicted class from NeuralNetwork
label  input  4  expected class from the label Memory (registered read of test_addr)
test_addr  output  ADDR_W  address driven to test-vector ROM and label Memory
nn_start  output  1  one-cycle start pulse to NeuralNetwork
busy  output  1  high from go acceptance until DONE entered
done  output  1  high in DONE state; cleared by next go or reset
correct_count  output  16  tests where result==label
total_count  output  16  tests scored so far
timeout_err  output  1  sticky; set if any test timed out in this campaign
score_valid  output  1  one-cycle pulse when a test is scored
score_hit  output  1  valid with score_valid: 1 = correct

Behaviour:
- Reset (rst==0 at edge): state IDLE; test_addr=0; nn_start=0; busy=0; done=0; counts=0; timeout_err=0; score_valid=0; score_hit=0; internal timers cleared. Reset mid-campaign aborts immediately; no partial score pulse.
- States:
  - IDLE/DONE --go--> SETUP. On go: test_addr<=base_addr; counts, timeout_err, done cleared; busy<=1.
  - SETUP: counts SETUP_CYC cycles, then -> ISSUE.
  - ISSUE: nn_start=1 for exactly this one cycle -> WAIT.
  - WAIT: watches for a rising edge of nn_finish (nn_finish==1 and registered previous value ==0). A finish already high on entry is NOT accepted.
    - Rising edge -> SCORE; capture hit = (nn_result==label) in the same cycle.
    - Wait timer reaches TIMEOUT-1 without an edge -> SCORE with hit=0 and timeout_err<=1.
  - SCORE: score_valid=1, score_hit=hit; total_count+1; correct_count+hit. If total_count (post-increment) == NUM_TESTS -> DONE, else -> SETUP with test_addr <= (test_addr+STRIDE) wrapped modulo NUM_VECTORS (subtract NUM_VECTORS if sum >= NUM_VECTORS; sum computed at ADDR_W+1 bits).
  - DONE: done=1, busy=0; test_addr holds last value.
- Latency: go to first nn_start = SETUP_CYC+1 cycles. Finish edge to score_valid = 1 cycle.
- go while busy: ignored. go in the same cycle as a finish edge: the finish is handled normally (not in IDLE).
- A finish edge seen outside WAIT is ignored, but the edge detector still tracks it.
- test_addr is stable from SETUP entry until the next SCORE, so label and input data are valid at compare.
- Counters saturate at 16'hFFFF (unreachable with legal NUM_TESTS).

Decomposition:
- Shared package nn_pkg: state encoding typedef (IDLE, SETUP, ISSUE, WAIT, SCORE, DONE), CLASS_W=4, default NUM_VECTORS/ADDR_W constants shared with the ROM and label Memory.
- One natural sub-module: nn_addr_stepper (registered address, load base, modular add of STRIDE). Everything else stays in the top FSM.

Test Plan:
- Reset mid-WAIT (rst=0 one cycle) -> next cycle state IDLE, nn_start=0, counts=0, busy=0; later go starts cleanly.
- Stub NN returns label on every test, NUM_TESTS=4, base_addr=0 -> nn_start at 3 cycles after go; done with correct_count=4, total_count=4, test_addr sequence 0,1,2,3.
- Wrap: base_addr=748, STRIDE=1, NUM_TESTS=4 -> addresses 748,749,0,1; STRIDE=300 from 600 -> 600,150,450.
- Stub answers label on odd tests, label+1 on even tests, NUM_TESTS=10 -> correct_count=5; score_hit alternates 0,1,0,1...
- Stub never finishes on test 2, TIMEOUT=16 -> scored wrong 16 cycles after entering WAIT, timeout_err=1, campaign completes, total_count=NUM_TESTS.
- Finish held high across ISSUE (stale level), then dropped and re-raised -> only the re-raise is scored. go pulsed while busy -> no restart, counts unaffected.

Source files
------------

// File: rtl/nn_pkg.sv
// Shared definitions for the NeuralNetwork test campaign logic.
// Holds the sequencer state encoding, the class-label width and the default
// test-vector ROM / label Memory geometry.
package nn_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ISSUE,
    ST_WAIT,
    ST_SCORE,
    ST_DONE
  } seq_state_e;

  localparam int unsigned CLASS_W        = 4;
  localparam int unsigned NN_ADDR_W      = 10;
  localparam int unsigned NN_NUM_VECTORS = 750;

endpackage

// File: rtl/nn_addr_stepper.sv
// Test-vector address register for nn_test_sequencer.
// Loads a base address, or advances by STRIDE modulo NUM_VECTORS.
// Ports:
//   clk   - system clock
//   rst   - synchronous active-low reset (address -> 0)
//   load  - load base into the address register (has priority over step)
//   base  - address to load
//   step  - advance the address by STRIDE with wrap
//   addr  - current registered address
module nn_addr_stepper #(
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned NUM_VECTORS = 750,
  parameter int unsigned STRIDE      = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [ADDR_W-1:0] base,
  input  logic              step,
  output logic [ADDR_W-1:0] addr
);

  localparam logic [ADDR_W:0] NV_W     = (ADDR_W+1)'(NUM_VECTORS);
  localparam logic [ADDR_W:0] STRIDE_W = (ADDR_W+1)'(STRIDE);

  logic [ADDR_W-1:0] addr_d, addr_q;
  logic [ADDR_W:0]   sum;

  // One extra bit keeps the carry so a single conditional subtract suffices
  // (addr < NUM_VECTORS and STRIDE < NUM_VECTORS bound the sum below 2*NV).
  always_comb begin
    sum    = {1'b0, addr_q} + STRIDE_W;
    addr_d = addr_q;
    if (load) begin
      addr_d = base;
    end else if (step) begin
      if (sum >= NV_W) begin
        addr_d = ADDR_W'(sum - NV_W);
      end else begin
        addr_d = sum[ADDR_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      addr_q <= '0;
    end else begin
      addr_q <= addr_d;
    end
  end

  assign addr = addr_q;

endmodule

// File: rtl/nn_test_sequencer.sv
// Runs a campaign of NUM_TESTS inferences through the NeuralNetwork core and
// scores each predicted class against the label Memory.
// Ports:
//   clk, rst          - clock and synchronous active-low reset
//   go, base_addr     - start a campaign at base_addr (accepted in IDLE/DONE)
//   nn_finish         - finish level from the core (rising edge in WAIT counts)
//   nn_result, label  - predicted class and expected class
//   test_addr         - address to the test-vector ROM and label Memory
//   nn_start          - one-cycle start pulse to the core
//   busy, done        - campaign running / campaign complete
//   correct_count     - tests with result == label
//   total_count       - tests scored so far
//   timeout_err       - sticky: some test in this campaign timed out
//   score_valid/hit   - one-cycle score pulse and its hit flag
module nn_test_sequencer
  import nn_pkg::*;
#(
  parameter int unsigned ADDR_W      = NN_ADDR_W,
  parameter int unsigned NUM_VECTORS = NN_NUM_VECTORS,
  parameter int unsigned NUM_TESTS   = 100,
  parameter int unsigned STRIDE      = 1,
  parameter int unsigned SETUP_CYC   = 2,
  parameter int unsigned TIMEOUT     = 4096
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               go,
  input  logic [ADDR_W-1:0]  base_addr,
  input  logic               nn_finish,
  input  logic [CLASS_W-1:0] nn_result,
  input  logic [CLASS_W-1:0] label,
  output logic [ADDR_W-1:0]  test_addr,
  output logic               nn_start,
  output logic               busy,
  output logic               done,
  output logic [15:0]        correct_count,
  output logic [15:0]        total_count,
  output logic               timeout_err,
  output logic               score_valid,
  output logic               score_hit
);

  localparam logic [15:0] NUM_TESTS_W = 16'(NUM_TESTS);

  seq_state_e  state_d, state_q;
  logic [31:0] timer_d, timer_q;
  logic        nn_start_d, nn_start_q;
  logic        busy_d, busy_q;
  logic        done_d, done_q;
  logic [15:0] correct_d, correct_q;
  logic [15:0] total_d, total_q;
  logic        tout_d, tout_q;
  logic        score_valid_d, score_valid_q;
  logic        score_hit_d, score_hit_q;
  logic        fin_prev_q;
  logic        fin_edge;
  logic        addr_load, addr_step;

  assign fin_edge = nn_finish & ~fin_prev_q;

  nn_addr_stepper #(
    .ADDR_W      (ADDR_W),
    .NUM_VECTORS (NUM_VECTORS),
    .STRIDE      (STRIDE)
  ) u_addr (
    .clk  (clk),
    .rst  (rst),
    .load (addr_load),
    .base (base_addr),
    .step (addr_step),
    .addr (test_addr)
  );

  // Score pulse, hit flag and counters are registered on the transition into
  // SCORE, so they are all visible together during the single SCORE cycle.
  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q;
    nn_start_d    = 1'b0;
    busy_d        = busy_q;
    done_d        = done_q;
    correct_d     = correct_q;
    total_d       = total_q;
    tout_d        = tout_q;
    score_valid_d = 1'b0;
    score_hit_d   = 1'b0;
    addr_load     = 1'b0;
    addr_step     = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (go) begin
          state_d   = ST_SETUP;
          timer_d   = '0;
          addr_load = 1'b1;
          correct_d = '0;
          total_d   = '0;
          tout_d    = 1'b0;
          done_d    = 1'b0;
          busy_d    = 1'b1;
        end
      end
      ST_SETUP: begin
        if (timer_q + 32'd1 >= SETUP_CYC) begin
          state_d    = ST_ISSUE;
          timer_d    = '0;
          nn_start_d = 1'b1;
        end else begin
          timer_d = timer_q + 32'd1;
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
        timer_d = '0;
      end
      ST_WAIT: begin
        if (fin_edge || (timer_q + 32'd1 >= TIMEOUT)) begin
          state_d       = ST_SCORE;
          timer_d       = '0;
          score_valid_d = 1'b1;
          score_hit_d   = fin_edge && (nn_result == label);
          tout_d        = tout_q | ~fin_edge;
          if (total_q != '1) begin
            total_d = total_q + 16'd1;
          end
          if (score_hit_d && (correct_q != '1)) begin
            correct_d = correct_q + 16'd1;
          end
        end else begin
          timer_d = timer_q + 32'd1;
        end
      end
      ST_SCORE: begin
        if (total_q == NUM_TESTS_W) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else begin
          state_d   = ST_SETUP;
          timer_d   = '0;
          addr_step = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      timer_q       <= '0;
      nn_start_q    <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      correct_q     <= '0;
      total_q       <= '0;
      tout_q        <= 1'b0;
      score_valid_q <= 1'b0;
      score_hit_q   <= 1'b0;
      fin_prev_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      nn_start_q    <= nn_start_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      correct_q     <= correct_d;
      total_q       <= total_d;
      tout_q        <= tout_d;
      score_valid_q <= score_valid_d;
      score_hit_q   <= score_hit_d;
      fin_prev_q    <= nn_finish;
    end
  end

  assign nn_start      = nn_start_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign correct_count = correct_q;
  assign total_count   = total_q;
  assign timeout_err   = tout_q;
  assign score_valid   = score_valid_q;
  assign score_hit     = score_hit_q;

endmodule

// File: tb/tb_nn_test_sequencer.sv
module tb_nn_test_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;

  // DUT A: NUM_TESTS=4, STRIDE=1, TIMEOUT=16
  logic        go_a = 1'b0;
  logic [9:0]  base_a = '0;
  logic        nn_finish_a;
  logic [3:0]  nn_result_a;
  logic [3:0]  label_a = '0;
  logic [9:0]  test_addr_a;
  logic        nn_start_a, busy_a, done_a, tout_a, sv_a, sh_a;
  logic [15:0] correct_a, total_a;

  // DUT B: NUM_TESTS=3, STRIDE=300
  logic        go_b = 1'b0;
  logic [9:0]  base_b = '0;
  logic        nn_finish_b = 1'b0;
  logic [3:0]  nn_result_b = '0;
  logic [3:0]  label_b = '0;
  logic [9:0]  test_addr_b;
  logic        nn_start_b, busy_b, done_b, tout_b, sv_b, sh_b;
  logic [15:0] correct_b, total_b;

  nn_test_sequencer #(
    .ADDR_W(10), .NUM_VECTORS(750), .NUM_TESTS(4), .STRIDE(1),
    .SETUP_CYC(2), .TIMEOUT(16)
  ) dut_a (
    .clk(clk), .rst(rst), .go(go_a), .base_addr(base_a),
    .nn_finish(nn_finish_a), .nn_result(nn_result_a), .label(label_a),
    .test_addr(test_addr_a), .nn_start(nn_start_a), .busy(busy_a),
    .done(done_a), .correct_count(correct_a), .total_count(total_a),
    .timeout_err(tout_a), .score_valid(sv_a), .score_hit(sh_a)
  );

  nn_test_sequencer #(
    .ADDR_W(10), .NUM_VECTORS(750), .NUM_TESTS(3), .STRIDE(300),
    .SETUP_CYC(2), .TIMEOUT(64)
  ) dut_b (
    .clk(clk), .rst(rst), .go(go_b), .base_addr(base_b),
    .nn_finish(nn_finish_b), .nn_result(nn_result_b), .label(label_b),
    .test_addr(test_addr_b), .nn_start(nn_start_b), .busy(busy_b),
    .done(done_b), .correct_count(correct_b), .total_count(total_b),
    .timeout_err(tout_b), .score_valid(sv_b), .score_hit(sh_b)
  );

  // Label Memory model: registered read, label = addr mod 10
  always @(posedge clk) label_a <= 4'(test_addr_a % 10'd10);

  // Stub NeuralNetwork for DUT A.
  // mode 0: always correct; mode 1: wrong on even test index (0-based);
  // mode 2: test index 1 never finishes.
  int         stub_mode = 0;
  int         st_idx = 0;
  int         st_dly = 0;
  int         st_hold = 0;
  bit         st_pend = 1'b0;
  logic       s_fin = 1'b0;
  logic [3:0] s_res = '0;
  logic       man = 1'b0;
  logic       man_fin = 1'b0;
  logic [3:0] man_res = '0;
  assign nn_finish_a = man ? man_fin : s_fin;
  assign nn_result_a = man ? man_res : s_res;

  always begin
    @(posedge clk); #1;
    if (!busy_a) begin
      st_idx = 0; st_pend = 1'b0; st_hold = 0; s_fin = 1'b0;
    end else begin
      if (s_fin) begin
        if (st_hold <= 1) s_fin = 1'b0;
        else st_hold--;
      end
      if (st_pend) begin
        if (st_dly <= 1) begin
          st_pend = 1'b0;
          if (!(stub_mode == 2 && st_idx == 1)) begin
            s_fin   = 1'b1;
            st_hold = 2;
            s_res   = (stub_mode == 1 && (st_idx % 2) == 0) ? label_a + 4'd1 : label_a;
          end
          st_idx++;
        end else begin
          st_dly--;
        end
      end
      if (nn_start_a) begin
        st_pend = 1'b1;
        st_dly  = 3;
      end
    end
  end

  // Stub for DUT B: one-cycle finish 3 cycles after start; label/result both 0
  logic [2:0] b_sh = '0;
  always begin
    @(posedge clk); #1;
    b_sh        = {b_sh[1:0], nn_start_b};
    nn_finish_b = b_sh[2];
  end

  // Monitors
  int         cyc = 0;
  logic       prev_fin = 1'b0;
  int         rise_cyc = 0;
  int         fin_lat = 0;
  int         start_cyc = 0;
  logic [9:0] addr_log[$];
  logic       hit_log[$];
  int         dlt_log[$];
  logic [9:0] addr_log_b[$];

  always begin
    @(posedge clk); #2;
    cyc++;
    if (nn_finish_a && !prev_fin) rise_cyc = cyc;
    prev_fin = nn_finish_a;
    if (nn_start_a) begin
      addr_log.push_back(test_addr_a);
      start_cyc = cyc;
    end
    if (sv_a) begin
      hit_log.push_back(sh_a);
      dlt_log.push_back(cyc - start_cyc);
      fin_lat = cyc - rise_cyc;
    end
    if (nn_start_b) addr_log_b.push_back(test_addr_b);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Stimulus helpers (no comparisons inside)
  task automatic clear_logs();
    addr_log.delete(); hit_log.delete(); dlt_log.delete(); addr_log_b.delete();
  endtask

  task automatic pulse_go_a(input logic [9:0] b);
    base_a = b; go_a = 1'b1;
    @(posedge clk); #1;
    go_a = 1'b0;
  endtask

  task automatic wait_start_a(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clk); #1;
      if (nn_start_a) seen = 1'b1;
    end
  endtask

  task automatic wait_done_a(output bit ok);
    ok = done_a;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(posedge clk); #1;
      ok = done_a;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_chk++; if (test_addr_a !== 10'd0) begin n_bad++; $display("FAIL reset_addr got=%0d exp=0", test_addr_a); end
    n_chk++; if ({nn_start_a, busy_a, done_a, tout_a, sv_a, sh_a} !== 6'b0) begin n_bad++; $display("FAIL reset_flags got=%b exp=000000", {nn_start_a, busy_a, done_a, tout_a, sv_a, sh_a}); end
    n_chk++; if ({correct_a, total_a} !== 32'd0) begin n_bad++; $display("FAIL reset_counts got=%0d/%0d exp=0/0", correct_a, total_a); end
    n_chk++; if ({test_addr_b, busy_b, done_b} !== 12'd0) begin n_bad++; $display("FAIL reset_b got=%0d busy=%b done=%b exp=0", test_addr_b, busy_b, done_b); end
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_wait();
    bit seen;
    bit stray;
    stub_mode = 0; man = 1'b0;
    clear_logs();
    pulse_go_a(10'd5);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(posedge clk); #1;
      if (sv_a) seen = 1'b1;
    end
    n_chk++; if (!seen) begin n_bad++; $display("FAIL midwait_first_score got=none exp=score_valid"); end
    wait_start_a(seen);
    n_chk++; if (!seen) begin n_bad++; $display("FAIL midwait_second_start got=none exp=nn_start"); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    n_chk++; if ({busy_a, nn_start_a, sv_a, done_a} !== 4'b0) begin n_bad++; $display("FAIL midwait_flags got=%b exp=0000", {busy_a, nn_start_a, sv_a, done_a}); end
    n_chk++; if ({correct_a, total_a} !== 32'd0) begin n_bad++; $display("FAIL midwait_counts got=%0d/%0d exp=0/0", correct_a, total_a); end
    n_chk++; if (test_addr_a !== 10'd0) begin n_bad++; $display("FAIL midwait_addr got=%0d exp=0", test_addr_a); end
    stray = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      if (sv_a || nn_start_a || busy_a) stray = 1'b1;
    end
    n_chk++; if (stray) begin n_bad++; $display("FAIL midwait_idle got=activity exp=quiet"); end
  endtask

  task automatic test_basic();
    bit ok;
    int lat;
    logic [9:0] exp_addr [4] = '{10'd0, 10'd1, 10'd2, 10'd3};
    stub_mode = 0; man = 1'b0;
    clear_logs();
    base_a = 10'd0; go_a = 1'b1;
    lat = 0; ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(posedge clk); #1;
      go_a = 1'b0;
      lat++;
      if (nn_start_a) ok = 1'b1;
    end
    n_chk++; if (lat !== 3) begin n_bad++; $display("FAIL basic_start_latency got=%0d exp=3", lat); end
    n_chk++; if (busy_a !== 1'b1) begin n_bad++; $display("FAIL basic_busy got=%b exp=1", busy_a); end
    wait_done_a(ok);
    n_chk++; if (!ok) begin n_bad++; $display("FAIL basic_done got=0 exp=1"); end
    n_chk++; if (correct_a !== 16'd4 || total_a !== 16'd4) begin n_bad++; $display("FAIL basic_counts got=%0d/%0d exp=4/4", correct_a, total_a); end
    n_chk++; if (busy_a !== 1'b0 || tout_a !== 1'b0) begin n_bad++; $display("FAIL basic_end_flags got=busy%b tout%b exp=busy0 tout0", busy_a, tout_a); end
    n_chk++; if (fin_lat !== 1) begin n_bad++; $display("FAIL basic_finish_to_score got=%0d exp=1", fin_lat); end
    n_chk++; if (addr_log.size() !== 4) begin n_bad++; $display("FAIL basic_addr_count got=%0d exp=4", addr_log.size()); end
    for (int i = 0; i < 4 && i < addr_log.size(); i++) begin
      n_chk++; if (addr_log[i] !== exp_addr[i]) begin n_bad++; $display("FAIL basic_addr[%0d] got=%0d exp=%0d", i, addr_log[i], exp_addr[i]); end
    end
    repeat (3) @(posedge clk);
    #1;
    n_chk++; if (test_addr_a !== 10'd3 || done_a !== 1'b1) begin n_bad++; $display("FAIL basic_hold got=%0d done=%b exp=3 done=1", test_addr_a, done_a); end
  endtask

  task automatic test_wrap();
    bit ok;
    logic [9:0] exp_addr [4] = '{10'd748, 10'd749, 10'd0, 10'd1};
    stub_mode = 0; man = 1'b0;
    clear_logs();
    pulse_go_a(10'd748);
    n_chk++; if (done_a !== 1'b0 || total_a !== 16'd0) begin n_bad++; $display("FAIL wrap_restart got=done%b total%0d exp=done0 total0", done_a, total_a); end
    wait_done_a(ok);
    n_chk++; if (!ok || total_a !== 16'd4 || correct_a !== 16'd4) begin n_bad++; $display("FAIL wrap_counts got=%0d/%0d exp=4/4", correct_a, total_a); end
    n_chk++; if (addr_log.size() !== 4) begin n_bad++; $display("FAIL wrap_addr_count got=%0d exp=4", addr_log.size()); end
    for (int i = 0; i < 4 && i < addr_log.size(); i++) begin
      n_chk++; if (addr_log[i] !== exp_addr[i]) begin n_bad++; $display("FAIL wrap_addr[%0d] got=%0d exp=%0d", i, addr_log[i], exp_addr[i]); end
    end
  endtask

  task automatic test_alternate();
    bit ok;
    logic exp_hit [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    stub_mode = 1; man = 1'b0;
    clear_logs();
    pulse_go_a(10'd20);
    wait_done_a(ok);
    n_chk++; if (!ok || correct_a !== 16'd2 || total_a !== 16'd4) begin n_bad++; $display("FAIL alt_counts got=%0d/%0d exp=2/4", correct_a, total_a); end
    n_chk++; if (hit_log.size() !== 4) begin n_bad++; $display("FAIL alt_score_count got=%0d exp=4", hit_log.size()); end
    for (int i = 0; i < 4 && i < hit_log.size(); i++) begin
      n_chk++; if (hit_log[i] !== exp_hit[i]) begin n_bad++; $display("FAIL alt_hit[%0d] got=%b exp=%b", i, hit_log[i], exp_hit[i]); end
    end
    n_chk++; if (tout_a !== 1'b0) begin n_bad++; $display("FAIL alt_tout got=%b exp=0", tout_a); end
  endtask

  task automatic test_timeout();
    bit ok;
    logic exp_hit [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    stub_mode = 2; man = 1'b0;
    clear_logs();
    pulse_go_a(10'd100);
    wait_done_a(ok);
    n_chk++; if (!ok || total_a !== 16'd4 || correct_a !== 16'd3) begin n_bad++; $display("FAIL tmo_counts got=%0d/%0d exp=3/4", correct_a, total_a); end
    n_chk++; if (tout_a !== 1'b1) begin n_bad++; $display("FAIL tmo_err got=%b exp=1", tout_a); end
    n_chk++; if (dlt_log.size() !== 4) begin n_bad++; $display("FAIL tmo_score_count got=%0d exp=4", dlt_log.size()); end
    if (dlt_log.size() >= 2) begin
      n_chk++; if (dlt_log[0] !== 4) begin n_bad++; $display("FAIL tmo_normal_delay got=%0d exp=4", dlt_log[0]); end
      n_chk++; if (dlt_log[1] !== 17) begin n_bad++; $display("FAIL tmo_timeout_delay got=%0d exp=17", dlt_log[1]); end
    end
    for (int i = 0; i < 4 && i < hit_log.size(); i++) begin
      n_chk++; if (hit_log[i] !== exp_hit[i]) begin n_bad++; $display("FAIL tmo_hit[%0d] got=%b exp=%b", i, hit_log[i], exp_hit[i]); end
    end
  endtask

  task automatic test_stale_and_busy_go();
    bit ok;
    bit early;
    logic [9:0] exp_addr [4] = '{10'd10, 10'd11, 10'd12, 10'd13};
    stub_mode = 0; man = 1'b1; man_fin = 1'b0; man_res = 4'd0;
    clear_logs();
    pulse_go_a(10'd10);
    n_chk++; if (tout_a !== 1'b0) begin n_bad++; $display("FAIL stale_tout_cleared got=%b exp=0", tout_a); end
    man_fin = 1'b1;
    wait_start_a(ok);
    n_chk++; if (!ok) begin n_bad++; $display("FAIL stale_start got=none exp=nn_start"); end
    early = 1'b0;
    for (int i = 0; i < 6; i++) begin
      base_a = 10'd0;
      go_a   = (i == 2);
      @(posedge clk); #1;
      if (sv_a) early = 1'b1;
    end
    go_a = 1'b0;
    n_chk++; if (early) begin n_bad++; $display("FAIL stale_level_scored got=score exp=none"); end
    n_chk++; if (test_addr_a !== 10'd10 || busy_a !== 1'b1 || total_a !== 16'd0) begin n_bad++; $display("FAIL busy_go_ignored got=addr%0d busy%b total%0d exp=addr10 busy1 total0", test_addr_a, busy_a, total_a); end
    man_fin = 1'b0;
    @(posedge clk); #1;
    man_res = 4'd0;
    man_fin = 1'b1;
    @(posedge clk); #1;
    n_chk++; if (sv_a !== 1'b1 || sh_a !== 1'b1) begin n_bad++; $display("FAIL stale_reraise got=valid%b hit%b exp=valid1 hit1", sv_a, sh_a); end
    n_chk++; if (total_a !== 16'd1 || correct_a !== 16'd1) begin n_bad++; $display("FAIL stale_first_counts got=%0d/%0d exp=1/1", correct_a, total_a); end
    man_fin = 1'b0;
    @(posedge clk); #1;
    man = 1'b0;
    wait_done_a(ok);
    n_chk++; if (!ok || total_a !== 16'd4 || correct_a !== 16'd4) begin n_bad++; $display("FAIL stale_final_counts got=%0d/%0d exp=4/4", correct_a, total_a); end
    for (int i = 0; i < 4 && i < addr_log.size(); i++) begin
      n_chk++; if (addr_log[i] !== exp_addr[i]) begin n_bad++; $display("FAIL stale_addr[%0d] got=%0d exp=%0d", i, addr_log[i], exp_addr[i]); end
    end
  endtask

  task automatic test_stride();
    bit ok;
    logic [9:0] exp_addr [3] = '{10'd600, 10'd150, 10'd450};
    clear_logs();
    base_b = 10'd600; go_b = 1'b1;
    @(posedge clk); #1;
    go_b = 1'b0;
    ok = done_b;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(posedge clk); #1;
      ok = done_b;
    end
    n_chk++; if (!ok || total_b !== 16'd3 || correct_b !== 16'd3) begin n_bad++; $display("FAIL stride_counts got=%0d/%0d exp=3/3", correct_b, total_b); end
    n_chk++; if (addr_log_b.size() !== 3) begin n_bad++; $display("FAIL stride_addr_count got=%0d exp=3", addr_log_b.size()); end
    for (int i = 0; i < 3 && i < addr_log_b.size(); i++) begin
      n_chk++; if (addr_log_b[i] !== exp_addr[i]) begin n_bad++; $display("FAIL stride_addr[%0d] got=%0d exp=%0d", i, addr_log_b[i], exp_addr[i]); end
    end
    n_chk++; if (test_addr_b !== 10'd450) begin n_bad++; $display("FAIL stride_hold got=%0d exp=450", test_addr_b); end
  endtask

  initial begin
    test_reset();
    test_reset_mid_wait();
    test_basic();
    test_wrap();
    test_alternate();
    test_timeout();
    test_stale_and_busy_go();
    test_stride();
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
